// File: rtl/uart_rx_fsm.sv
// UART receiver for the FPGA<->ARM serial link: 8 data bits LSB-first, even parity, one stop bit.
// Each received byte gets a one-cycle valid strobe plus held parity and framing error flags.
module uart_rx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 1667,
    parameter int unsigned HALF_BIT     = 833
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_in,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    // Terminal counts: the counter reads N-1 on the Nth edge after it was cleared.
    localparam logic [10:0] BitLast  = 11'(CLKS_PER_BIT - 1);
    localparam logic [10:0] HalfLast = 11'(HALF_BIT - 1);

    logic        r_sync1, r_sync2;
    state_e      r_state, w_state;
    logic [10:0] r_cnt, w_cnt;
    logic [2:0]  r_bit_cnt, w_bit_cnt;
    logic [7:0]  r_shift, w_shift;
    logic        r_par_calc, w_par_calc;
    logic [7:0]  r_rx_data, w_rx_data;
    logic        r_valid, w_valid;
    logic        r_perr, w_perr;
    logic        r_ferr, w_ferr;
    logic        r_busy, w_busy;
    logic        w_rxs;

    assign w_rxs = r_sync2;

    // Two-flop synchroniser for the asynchronous serial line; idles high out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_calc <= 1'b0;
            r_rx_data  <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_shift    <= w_shift;
            r_par_calc <= w_par_calc;
            r_rx_data  <= w_rx_data;
            r_valid    <= w_valid;
            r_perr     <= w_perr;
            r_ferr     <= w_ferr;
            r_busy     <= w_busy;
        end
    end

    // Next-state and sampling decisions; counter cleared on every transition and sample.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt + 11'd1;
        w_bit_cnt  = r_bit_cnt;
        w_shift    = r_shift;
        w_par_calc = r_par_calc;
        w_rx_data  = r_rx_data;
        w_valid    = 1'b0;
        w_perr     = r_perr;
        w_ferr     = r_ferr;
        w_busy     = r_busy;
        unique case (r_state)
            StIdle: begin
                w_cnt = '0;
                if (!w_rxs) begin
                    w_state = StStart;
                    w_busy  = 1'b1;
                end
            end
            StStart: begin
                if (r_cnt == HalfLast) begin
                    w_cnt     = '0;
                    w_bit_cnt = '0;
                    if (!w_rxs) begin
                        w_state = StData;
                    end else begin
                        // Line went back high before mid-bit: treat as noise.
                        w_state = StIdle;
                        w_busy  = 1'b0;
                    end
                end
            end
            StData: begin
                if (r_cnt == BitLast) begin
                    w_cnt     = '0;
                    w_shift   = {w_rxs, r_shift[7:1]};
                    w_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state = StParity;
                    end
                end
            end
            StParity: begin
                if (r_cnt == BitLast) begin
                    w_cnt      = '0;
                    w_par_calc = (^r_shift) ^ w_rxs;
                    w_state    = StStop;
                end
            end
            StStop: begin
                if (r_cnt == BitLast) begin
                    w_cnt     = '0;
                    w_rx_data = r_shift;
                    w_perr    = r_par_calc;
                    w_ferr    = !w_rxs;
                    w_valid   = 1'b1;
                    if (w_rxs) begin
                        w_state = StIdle;
                        w_busy  = 1'b0;
                    end else begin
                        w_state = StBreak;
                    end
                end
            end
            StBreak: begin
                // Wait out a held-low line so it is not mistaken for a new start bit.
                w_cnt = '0;
                if (w_rxs) begin
                    w_state = StIdle;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = StIdle;
                w_cnt   = '0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_busy       = r_busy;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

UART receiver: the receive-side counterpart of the board's UART transmitter on the FPGA↔ARM serial link. It deserialises 11-bit frames (start, 8 data LSB-first, even parity, stop) at 9600 baud from a 16 MHz clock. Each received byte is presented with a one-cycle valid strobe and error flags. Downstream it feeds the motor-command decoder.

## Interface
- `CLKS_PER_BIT`, 1667: clock cycles per bit (16 MHz / 9600).
- `HALF_BIT`, 833: cycles from the detected start edge to the start-bit mid-point check.
- `clk` in 1: system clock, 16 MHz, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_in` in 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out 8: last received byte, held until the next completed frame.
- `rx_valid` out 1: one-cycle pulse per completed frame.
- `parity_err` out 1: even-parity mismatch for the frame; valid with `rx_valid`, held until the next frame.
- `frame_err` out 1: stop bit sampled low; valid with `rx_valid`, held until the next frame.
- `busy` out 1: high while a frame is being received.

## Operation
- `rx_in` passes through a 2-flop synchroniser. The synchroniser flops reset to 1. All logic below uses the synchronised value `rxs`.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. State is IDLE, bit counter 0, cycle counter 0.
- Asserting reset mid-frame discards the partial frame and produces no `rx_valid`.
- States:
  - IDLE: when `rxs`=0, go to START, clear the cycle counter, set `busy`=1.
  - START: count HALF_BIT cycles, then sample. `rxs`=0 → DATA. `rxs`=1 → IDLE with `busy`=0 (glitch rejected, no outputs change).
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit 7 → PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit. `parity_err` = XOR of the 8 data bits XOR the parity bit; even parity means this is 0 when correct.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - Update `rx_data`, `parity_err` and `frame_err`, and pulse `rx_valid` for one cycle.
    - Stop=1 → IDLE, `busy`=0.
    - Stop=0 → `frame_err`=1 and go to BREAK.
  - BREAK: hold `busy`=1 until `rxs`=1, then → IDLE with `busy`=0. This prevents a held-low line or break from being decoded as a new start bit.
- `rx_valid` fires for every frame that reaches STOP, including frames with errors. Consumers must qualify `rx_data` with both error flags.
- The cycle counter is at least 11 bits. It is cleared on every state transition and on every sample.

## Timing
- Let T0 be the first rising edge at which `rxs`=0 in IDLE (2–3 cycles after `rx_in` falls).
- Start check at T0+HALF_BIT (833).
- Data bit k (k=0..7) sampled at T0+HALF_BIT+(k+1)·CLKS_PER_BIT.
- Parity sampled at T0+833+9·1667 = T0+15836.
- Stop sampled at T0+833+10·1667 = T0+17503.
- `rx_valid` is high in the cycle after the stop sample; the registered outputs update together in that cycle.
- Back-to-back frames: IDLE is re-entered at the stop mid-point, so a start edge arriving any time after that is caught. The minimum inter-frame gap is 0 idle bits.
- Tolerance: the bench accepts `rx_valid` within ±3 cycles of the nominal time.
- `busy` rises 1 cycle after T0 and falls in the same cycle as `rx_valid`, or when BREAK exits.

## Test plan
- Reset, then send frame 0x55 (parity 0, stop 1) → exactly one `rx_valid`, `rx_data`=0x55, `parity_err`=0, `frame_err`=0.
- Send back-to-back frames with no idle gap: 0xAA, 0xF0, then 0x01 (parity 1) → three `rx_valid` pulses in order carrying 0xAA, 0xF0 and 0x01, all with errors 0.
- Send 0x55 with the parity bit set to 1 → `rx_valid` pulses, `rx_data`=0x55, `parity_err`=1, `frame_err`=0.
- Send 0x3C with the stop bit 0 and hold the line low for 5 bit times → `rx_valid` with `frame_err`=1. No further `rx_valid` occurs while the line stays low. `busy` falls once the line returns high.
- Drive a 400-cycle low glitch on an idle line → no `rx_valid`, `rx_data` unchanged, `busy` back to 0 about 835 cycles after the glitch.
- Assert reset during data bit 4 of a frame, release it, then send 0xC3 → no pulse for the aborted frame, and one `rx_valid` with `rx_data`=0xC3.
